// File: rtl/bl_wl_config_programmer.sv
// Bitline/wordline driver for the configuration SRAM fabric: takes one row per
// valid/ready handshake, drives it on bl, then pulses exactly one wordline.
//
//   state | meaning
//   IDLE  | waiting for a row (ready unless done/err)
//   SETUP | bl driven, wl low, SETUP_CYCLES cycles
//   PULSE | wl[cur_row] high, PULSE_CYCLES cycles
//   HOLD  | wl low, bl still held, HOLD_CYCLES cycles
module bl_wl_config_programmer #(
    parameter int NUM_BL       = 8,
    parameter int NUM_WL       = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [NUM_BL-1:0] cfg_data,
    input  logic              cfg_last,
    output logic [NUM_BL-1:0] bl,
    output logic [NUM_WL-1:0] wl,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int MAX_CYC = (SETUP_CYCLES > PULSE_CYCLES)
                           ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                           : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;
    localparam int RW = $clog2(NUM_WL);

    localparam logic [CW-1:0]     SETUP_LOAD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0]     PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0]     HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0]     LAST_ROW   = RW'(NUM_WL - 1);
    localparam logic [NUM_WL-1:0] WL_ONE     = NUM_WL'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [RW-1:0] row;
    logic [RW-1:0] cur_row;
    logic          last_flag;
    logic          err_flag;
    logic          armed;
    logic          accept;
    logic          hold_exit;
    logic          row_err;

    // armed keeps ready low until the first edge after reset release
    assign cfg_ready = armed && (state == IDLE) && !done && !err;
    assign accept    = cfg_valid && cfg_ready;
    assign busy      = (state != IDLE);
    assign row_err   = cfg_last ? (row != LAST_ROW) : (row == LAST_ROW);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold_exit = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = PULSE;
                    cnt_nxt   = PULSE_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    hold_exit = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state     <= IDLE;
            cnt       <= '0;
            row       <= '0;
            cur_row   <= '0;
            bl        <= '0;
            last_flag <= 1'b0;
            err_flag  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            armed     <= 1'b0;
        end else begin
            armed <= 1'b1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                bl        <= cfg_data;
                last_flag <= cfg_last;
                err_flag  <= row_err;
                cur_row   <= row;
            end
            // row saturates; reaching the last row always ends in done or err
            if (hold_exit) begin
                bl <= '0;
                if (row != LAST_ROW) begin
                    row <= row + 1'b1;
                end
                if (err_flag) begin
                    err <= 1'b1;
                end else if (last_flag) begin
                    done <= 1'b1;
                end
            end
        end
    end

    // wl decoded from state so reset clears it in the same cycle
    always_comb begin
        wl = '0;
        if (state == PULSE) begin
            wl = WL_ONE << cur_row;
        end
    end

endmodule

// File: tb/tb_bl_wl_config_programmer.sv
// Bench for bl_wl_config_programmer: two instances (default timing and 3/1/2
// timing) driven with directed and random rows, checked against a row-level model.
module tb_bl_wl_config_programmer;

    localparam int NWL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid   [2];
    logic [7:0] data    [2];
    logic       last    [2];
    logic       ready_o [2];
    logic [7:0] bl_o    [2];
    logic [3:0] wl_o    [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       err_o   [2];

    int total = 0;
    int bad   = 0;

    int s_arr [2] = '{1, 3};
    int p_arr [2] = '{2, 1};
    int h_arr [2] = '{1, 2};

    int m_row  [2];
    bit m_done [2];
    bit m_err  [2];

    always #5 clk = ~clk;

    bl_wl_config_programmer #(
        .NUM_BL(8), .NUM_WL(NWL), .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1)
    ) dut0 (
        .prog_clk(clk), .pReset(rst),
        .cfg_valid(valid[0]), .cfg_ready(ready_o[0]), .cfg_data(data[0]), .cfg_last(last[0]),
        .bl(bl_o[0]), .wl(wl_o[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
    );

    bl_wl_config_programmer #(
        .NUM_BL(8), .NUM_WL(NWL), .SETUP_CYCLES(3), .PULSE_CYCLES(1), .HOLD_CYCLES(2)
    ) dut1 (
        .prog_clk(clk), .pReset(rst),
        .cfg_valid(valid[1]), .cfg_ready(ready_o[1]), .cfg_data(data[1]), .cfg_last(last[1]),
        .bl(bl_o[1]), .wl(wl_o[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
    );

    task automatic chk(input string tag, input int d, input string sig,
                       input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s dut%0d %s observed=%0h expected=%0h", tag, d, sig, obs, exp_v);
        end
    endtask

    task automatic check_all(input int d, input string tag, input logic [7:0] e_bl,
                             input logic [3:0] e_wl, input logic e_busy, input logic e_ready,
                             input logic e_done, input logic e_err);
        chk(tag, d, "bl",    32'(bl_o[d]),    32'(e_bl));
        chk(tag, d, "wl",    32'(wl_o[d]),    32'(e_wl));
        chk(tag, d, "busy",  32'(busy_o[d]),  32'(e_busy));
        chk(tag, d, "ready", 32'(ready_o[d]), 32'(e_ready));
        chk(tag, d, "done",  32'(done_o[d]),  32'(e_done));
        chk(tag, d, "err",   32'(err_o[d]),   32'(e_err));
    endtask

    // Asserts reset (expects immediate clearing), releases on a falling edge and
    // expects the blocks ready one clock later. Returns on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) valid[d] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check_all(d, "reset", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_row[d]  = 0;
            m_done[d] = 1'b0;
            m_err[d]  = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_all(d, "post_reset", 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // One row offered to dut d. keep_valid holds valid high with junk data while
    // busy; abort_at >= 0 asserts reset after that many cycles into the write.
    task automatic write_row(input int d, input logic [7:0] dat, input logic lst,
                             input bit keep_valid, input int abort_at);
        int s, p, h, len;
        bit exp_acc, bad_row;
        logic [3:0] exp_wl;
        logic [7:0] e_bl;
        logic [3:0] e_wl;
        s   = s_arr[d];
        p   = p_arr[d];
        h   = h_arr[d];
        len = s + p + h;
        valid[d] = 1'b1;
        data[d]  = dat;
        last[d]  = lst;
        exp_acc  = !m_done[d] && !m_err[d];
        chk("offer", d, "ready", 32'(ready_o[d]), 32'(exp_acc));
        if (!exp_acc) begin
            for (int i = 0; i < len + 2; i++) begin
                @(posedge clk);
                @(negedge clk);
                check_all(d, "ignored", 8'h00, 4'h0, 1'b0, 1'b0, m_done[d], m_err[d]);
            end
            valid[d] = 1'b0;
            return;
        end
        exp_wl = 4'b0001 << m_row[d];
        @(posedge clk);
        for (int t = 0; t <= len; t++) begin
            @(negedge clk);
            if (t == 0) begin
                valid[d] = keep_valid;
                data[d]  = 8'($urandom);
                last[d]  = 1'($urandom);
            end
            if (t == len) begin
                valid[d] = 1'b0;
                bad_row  = lst ? (m_row[d] != NWL - 1) : (m_row[d] == NWL - 1);
                if (bad_row) m_err[d] = 1'b1;
                else if (lst) m_done[d] = 1'b1;
                if (m_row[d] < NWL - 1) m_row[d]++;
            end
            e_bl = (t < len) ? dat : 8'h00;
            e_wl = (t >= s && t < s + p) ? exp_wl : 4'h0;
            check_all(d, "write", e_bl, e_wl, t < len, (t == len) && !m_done[d] && !m_err[d],
                      m_done[d], m_err[d]);
            if (t == abort_at) begin
                do_reset();
                return;
            end
        end
        valid[d] = 1'b0;
    endtask

    initial begin
        int r;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0;
            data[d]  = 8'h00;
            last[d]  = 1'b0;
        end
        #2;
        do_reset();

        // single row with backpressure, then reset in the middle of the row 2 pulse
        write_row(0, 8'hA5, 1'b0, 1'b1, -1);
        write_row(0, 8'($urandom), 1'b0, 1'b1, -1);
        write_row(0, 8'($urandom), 1'b0, 1'b1, s_arr[0]);

        // full bitstream, rows back to back, then an offer after done
        write_row(0, 8'h01, 1'b0, 1'b1, -1);
        write_row(0, 8'h02, 1'b0, 1'b1, -1);
        write_row(0, 8'h04, 1'b0, 1'b1, -1);
        write_row(0, 8'h08, 1'b1, 1'b1, -1);
        write_row(0, 8'($urandom), 1'b0, 1'b1, -1);

        // early last on row 1
        do_reset();
        write_row(0, 8'($urandom), 1'b0, 1'b0, -1);
        write_row(0, 8'($urandom), 1'b1, 1'b0, -1);
        write_row(0, 8'($urandom), 1'b1, 1'b1, -1);

        // missing last
        do_reset();
        for (int i = 0; i < 5; i++) write_row(0, 8'($urandom), 1'b0, 1'b1, -1);

        // alternate timing: full bitstream, then reset during its first pulse
        for (int i = 0; i < NWL; i++) write_row(1, 8'($urandom), i == NWL - 1, 1'b1, -1);
        write_row(1, 8'($urandom), 1'b1, 1'b1, -1);
        write_row(1, 8'($urandom), 1'b0, 1'b1, -1);
        do_reset();
        write_row(1, 8'($urandom), 1'b0, 1'b0, s_arr[1]);

        // random streams: last placed on a random row (NWL means never)
        for (int it = 0; it < 6; it++) begin
            int d;
            d = it % 2;
            r = $urandom_range(0, NWL);
            do_reset();
            for (int i = 0; i <= NWL; i++)
                write_row(d, 8'($urandom), i == r, 1'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
